// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for an in-order pipeline.
// A shift-register scoreboard tracks producers after EX; selects and stall are combinational.
module fwd_hazard_unit #(
  parameter  int AW       = 5,
  parameter  int DEPTH    = 2,
  parameter  int NSRC     = 3,
  parameter  int LOAD_LAT = 1,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ex_valid,
  input  logic [NSRC*AW-1:0]   i_ex_src,
  input  logic [NSRC-1:0]      i_ex_src_used,
  input  logic [AW-1:0]        i_ex_dest,
  input  logic                 i_ex_wb_en,
  input  logic                 i_ex_is_load,
  input  logic                 i_flush,
  output logic [NSRC*SELW-1:0] o_fwd_sel,
  output logic                 o_stall,
  output logic                 o_stall_active,
  output logic [15:0]          o_stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_stall_count;
  logic            r_sb_valid [1:DEPTH];
  logic [AW-1:0]   r_sb_dest  [1:DEPTH];
  logic            r_sb_wb    [1:DEPTH];
  logic            r_sb_load  [1:DEPTH];
  logic [NSRC-1:0] w_hazard;
  logic            w_issue;

  assign w_issue = i_ex_valid & ~o_stall & ~i_flush;

  // Entry 1 receives the EX instruction or a bubble; older entries just age.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_sb_valid[k] <= 1'b0;
        r_sb_dest[k]  <= '0;
        r_sb_wb[k]    <= 1'b0;
        r_sb_load[k]  <= 1'b0;
      end
    end else begin
      r_sb_valid[1] <= w_issue;
      r_sb_dest[1]  <= i_ex_dest;
      r_sb_wb[1]    <= i_ex_wb_en;
      r_sb_load[1]  <= i_ex_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        r_sb_valid[k] <= r_sb_valid[k-1];
        r_sb_dest[k]  <= r_sb_dest[k-1];
        r_sb_wb[k]    <= r_sb_wb[k-1];
        r_sb_load[k]  <= r_sb_load[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [AW-1:0]   w_src;
      logic [SELW-1:0] w_sel;
      logic            w_hz;

      assign w_src = i_ex_src[gi*AW +: AW];

      // Scan oldest to youngest so the youngest match wins; a too-young load blocks forwarding.
      always_comb begin
        w_sel = '0;
        w_hz  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (r_sb_valid[k] && r_sb_wb[k] && (r_sb_dest[k] == w_src) &&
              (w_src != '0) && i_ex_src_used[gi]) begin
            w_sel = SELW'(k);
            w_hz  = r_sb_load[k] && (k <= LOAD_LAT);
          end
        end
        if (w_hz) w_sel = '0;
      end

      assign o_fwd_sel[gi*SELW +: SELW] = w_sel;
      assign w_hazard[gi]               = w_hz;
    end
  endgenerate

  assign o_stall = i_ex_valid & ~i_flush & (|w_hazard);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (o_stall)  w_state_next = STALL;
      STALL:   if (!o_stall) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_count <= '0;
    else if (o_stall && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end

  assign o_stall_active = (r_state == STALL);
  assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit with the default parameter set.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [14:0] ex_src = '0;
  logic [2:0]  ex_src_used = '0;
  logic [4:0]  ex_dest = '0;
  logic        ex_wb_en = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic        stall_active;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5), .DEPTH(2), .NSRC(3), .LOAD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_src(ex_src),
    .i_ex_src_used(ex_src_used), .i_ex_dest(ex_dest), .i_ex_wb_en(ex_wb_en),
    .i_ex_is_load(ex_is_load), .i_flush(flush), .o_fwd_sel(fwd_sel),
    .o_stall(stall), .o_stall_active(stall_active), .o_stall_count(stall_count)
  );

  typedef struct {
    logic       v;
    logic [4:0] s0, s1, s2;
    logic [2:0] used;
    logic [4:0] dest;
    logic       wb, ld, fl;
    logic [5:0] esel;
    logic       est, eact;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [4:0] s0, logic [4:0] s1, logic [4:0] s2,
                              logic [2:0] used, logic [4:0] dest, logic wb, logic ld,
                              logic fl, logic [5:0] esel, logic est, logic eact,
                              logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.s2 = s2; r.used = used; r.dest = dest;
    r.wb = wb; r.ld = ld; r.fl = fl; r.esel = esel; r.est = est; r.eact = eact;
    r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] used, input logic [4:0] dest,
                       input logic wb, input logic ld, input logic fl);
    ex_valid = v; ex_src = {s2, s1, s0}; ex_src_used = used;
    ex_dest = dest; ex_wb_en = wb; ex_is_load = ld; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ALU back-to-back forwarding
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 6'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 6'h00, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 3'b001, 0, 0, 0, 0, {2'd0, 2'd0, 2'd1}, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 3'b010, 0, 0, 0, 0, {2'd0, 2'd2, 2'd0}, 0, 0, 0));
    // load-use: one stall cycle then forward from stage 2
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 4, 1, 1, 0, 6'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4, 0, 3'b010, 7, 1, 0, 0, 6'h00, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4, 0, 3'b010, 7, 1, 0, 0, {2'd0, 2'd2, 2'd0}, 0, 1, 1));
    // priority: youngest producer wins
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 6'h00, 0, 0, 1));
    tbl.push_back(mk(1, 7, 0, 0, 3'b001, 5, 1, 0, 0, {2'd0, 2'd0, 2'd2}, 0, 0, 1));
    tbl.push_back(mk(1, 5, 0, 0, 3'b001, 0, 0, 0, 0, {2'd0, 2'd0, 2'd1}, 0, 0, 1));
    // load r6 at stage 1 shadows add r6 at stage 2
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 6, 1, 0, 0, 6'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 6, 1, 1, 0, 6'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6, 3'b100, 0, 0, 0, 0, 6'h00, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 6, 3'b100, 0, 0, 0, 0, {2'd2, 2'd0, 2'd0}, 0, 1, 2));
    // r0 never forwards; unused operands never match
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 6'h00, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 3'b111, 9, 1, 0, 0, 6'h00, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 10, 1, 1, 0, 6'h00, 0, 0, 2));
    tbl.push_back(mk(1, 10, 9, 0, 3'b010, 0, 0, 0, 0, {2'd0, 2'd2, 2'd0}, 0, 0, 2));
    // flush suppresses the stall and inserts a bubble, keeping older entries
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 11, 1, 1, 0, 6'h00, 0, 0, 2));
    tbl.push_back(mk(1, 11, 0, 0, 3'b001, 12, 1, 0, 1, 6'h00, 0, 0, 2));
    tbl.push_back(mk(1, 12, 11, 0, 3'b011, 0, 0, 0, 0, {2'd0, 2'd2, 2'd0}, 0, 0, 2));

    #12;
    check("reset_fwd_sel", 16'(fwd_sel), 16'h0);
    check("reset_stall", 16'(stall), 16'h0);
    check("reset_stall_active", 16'(stall_active), 16'h0);
    check("reset_stall_count", stall_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].used, tbl[i].dest,
            tbl[i].wb, tbl[i].ld, tbl[i].fl);
      #2;
      $display("vec %0d: sel=%h stall=%0d active=%0d count=%0d", i, fwd_sel, stall,
               stall_active, stall_count);
      check($sformatf("vec%0d_fwd_sel", i), 16'(fwd_sel), 16'(tbl[i].esel));
      check($sformatf("vec%0d_stall", i), 16'(stall), 16'(tbl[i].est));
      check($sformatf("vec%0d_stall_active", i), 16'(stall_active), 16'(tbl[i].eact));
      check($sformatf("vec%0d_stall_count", i), stall_count, tbl[i].ecnt);
      next_cycle();
    end

    // asynchronous reset while the FSM sits in STALL
    drive(1, 0, 0, 0, 3'b000, 4, 1, 1, 0);
    next_cycle();
    drive(1, 0, 4, 0, 3'b010, 0, 0, 0, 0);
    #2;
    check("rst_seq_stall", 16'(stall), 16'h1);
    next_cycle();
    #1;
    check("rst_seq_pre_sel", 16'(fwd_sel), 16'(6'b00_10_00));
    check("rst_seq_pre_active", 16'(stall_active), 16'h1);
    check("rst_seq_pre_count", stall_count, 16'd3);
    rst_n = 1'b0;
    #1;
    $display("async reset: sel=%h stall=%0d active=%0d count=%0d", fwd_sel, stall,
             stall_active, stall_count);
    check("rst_async_sel", 16'(fwd_sel), 16'h0);
    check("rst_async_stall", 16'(stall), 16'h0);
    check("rst_async_active", 16'(stall_active), 16'h0);
    check("rst_async_count", stall_count, 16'h0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    check("post_rst_active", 16'(stall_active), 16'h0);
    check("post_rst_count", stall_count, 16'h0);
    check("post_rst_sel", 16'(fwd_sel), 16'h0);

    // saturation from a preloaded count
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    force dut.r_stall_count = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    next_cycle();
    for (int n = 1; n <= 3; n++) begin
      drive(1, 0, 0, 0, 3'b000, 4, 1, 1, 0);
      next_cycle();
      drive(1, 0, 4, 0, 3'b010, 0, 0, 0, 0);
      #1;
      check($sformatf("sat%0d_stall", n), 16'(stall), 16'h1);
      next_cycle();
      $display("saturation stall %0d: count=%h", n, stall_count);
      check($sformatf("sat%0d_count", n), stall_count, 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
